req_onehot_capture: RTL and testbench
=====================================

# req_onehot_capture

Front-end stage that feeds the 4-to-2 encoder with a clean, strictly one-hot request vector. Four raw, asynchronous request lines are synchronized, debounced and rising-edge detected. Detected events queue as pending bits and are issued one at a time, round-robin, on a held one-hot output with a valid/ack handshake. The encoder input therefore never sees zero-or-multi-hot ambiguity while `valid` is high.

## Interface
- `DB_CYCLES`, 4, consecutive cycles a synchronized level must differ from the debounced level before it is accepted; legal range 1..255
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req_in`  input  4  raw request lines, asynchronous to `clk`
- `ack`  input  1  downstream has consumed the current `onehot`
- `onehot`  output  4  registered one-hot grant; 4'b0000 when `valid`=0
- `valid`  output  1  registered; `onehot` holds a grant
- `pending`  output  4  registered queued-event bits, not yet granted
- `overflow`  output  1  registered one-cycle pulse: an edge arrived on a bit already pending (event lost)

## Operation
- Reset values: `onehot`=0, `valid`=0, `pending`=0, `overflow`=0; sync flops, debounced levels, debounce counters = 0; last-grant pointer = 3, so bit 0 has first priority; FSM in IDLE.
- Synchronizer: two flops per bit (`s1`, `s2`); only `s2` is used downstream.
- Debounce, per bit: the counter is 8 bits wide.
  - If `s2` equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When `s2` has differed for the `DB_CYCLES`-th consecutive cycle, the debounced level takes `s2` and the counter clears.
  - Glitches shorter than `DB_CYCLES` cycles are discarded.
- Edge detect: a 0->1 transition of the debounced level sets the corresponding `pending` bit on the next edge.
  - 1->0 transitions are ignored.
  - If that `pending` bit is already 1 and is not being granted in the same cycle, `pending` is unchanged and `overflow` pulses for one cycle.
- FSM IDLE:
  - If `pending`≠0, select the first set bit searching ascending from (last+1) mod 4 with wrap.
  - Load `onehot` with that bit and set `valid`=1.
  - Clear that `pending` bit, update last := selected, go to HOLD.
  - If `pending`=0, stay in IDLE.
- FSM HOLD: `onehot`/`valid` stay stable until `ack`=1. On `ack`, `onehot`=0, `valid`=0, go to IDLE. `ack` while IDLE is ignored.
- Simultaneous grant-clear and new edge on the same bit: the set wins. `pending` stays 1 and there is no overflow.
- Reset mid-operation: all state returns to reset values immediately, and queued events are dropped.

## Timing
- `req_in` rises and is stable before edge 0 with DB_CYCLES=N:
  - `s2`=1 after edge 1.
  - The debounced level rises at edge N+1.
  - `pending` is set at edge N+2.
  - `valid`/`onehot` assert at edge N+3 if the FSM is IDLE.
- Handshake: a grant completes on the edge where `valid`=1 and `ack`=1. `valid` is low for at least one cycle between grants. Peak throughput is one grant per 2 cycles.
- `onehot` is never multi-hot. `onehot`≠0 if and only if `valid`=1.
- `overflow` is high for exactly one cycle per lost event.

## Test plan
- Reset, then `req_in`=4'b0010 held with N=4 -> `valid` rises at edge 7 with `onehot`=4'b0010; `pending` is 4'b0010 during cycle 6 only.
- 2-cycle pulse on `req_in[0]` with N=4 -> debounced level never rises; `pending`, `valid`, `overflow` all stay 0.
- `req_in` 4'b0000→4'b1111 together, `ack` pulsed one cycle after each grant -> grants in order 0001, 0010, 0100, 1000; `pending` steps 1110→1100→1000→0000.
- Round-robin wrap: last grant = bit 2, with bits 0 and 3 pending -> next `onehot`=4'b1000, then 4'b0001.
- Bit 1 pending, second debounced edge on bit 1 while `ack` withheld -> `overflow` high for exactly one cycle, and `pending[1]` is still 1.
- `rst` asserted while `valid`=1 and `pending`=4'b0101 -> all outputs 0 at once. After release, bit 0 has first priority.

Source files
------------

// File: rtl/req_onehot_capture.sv
// req_onehot_capture: synchronizes, debounces and rising-edge detects four raw
// request lines, queues detected events as pending bits, and issues them one
// at a time, round-robin, as a held one-hot grant with a valid/ack handshake.
module req_onehot_capture #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       ack,
  output logic [3:0] onehot,
  output logic       valid,
  output logic [3:0] pending,
  output logic       overflow
);

  // Counter value on the last differing cycle before the new level is taken.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] w_db;
  logic [3:0] r_db_prev;
  logic [3:0] w_rise;

  logic [3:0] r_pending;
  logic [3:0] w_pending_next;
  logic       r_overflow;
  logic       w_overflow_next;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_onehot;
  logic [3:0] w_onehot_next;
  logic       r_valid;
  logic       w_valid_next;
  logic [1:0] r_last;
  logic [1:0] w_last_next;
  logic [3:0] w_grant_clr;

  logic       w_sel_found;
  logic [1:0] w_sel_idx;

  // Two-flop synchronizer for the asynchronous request lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 4'b0000;
      r_s2 <= 4'b0000;
    end else begin
      r_s1 <= req_in;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debounce: accept a new level only after it has persisted for
  // DB_CYCLES consecutive cycles; any return to the old level restarts.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      logic [7:0] r_cnt;
      logic       r_db;

      // Debounce counter and accepted level for this bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= 8'd0;
          r_db  <= 1'b0;
        end else if (r_s2[gi] == r_db) begin
          r_cnt <= 8'd0;
        end else if (r_cnt == DB_LAST) begin
          r_db  <= r_s2[gi];
          r_cnt <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end

      assign w_db[gi] = r_db;
    end
  endgenerate

  // Delayed copy of the debounced levels for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_prev <= 4'b0000;
    end else begin
      r_db_prev <= w_db;
    end
  end

  assign w_rise = w_db & ~r_db_prev;

  // Round-robin pick: first pending bit ascending from last+1, wrapping.
  always_comb begin
    logic [1:0] cand;
    w_sel_found = 1'b0;
    w_sel_idx   = r_last;
    cand        = r_last;
    for (int k = 0; k < 4; k++) begin
      cand = cand + 2'd1;
      if (!w_sel_found && r_pending[cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = cand;
      end
    end
  end

  // Grant FSM next state: issue from IDLE, hold until ack.
  always_comb begin
    w_state_next  = r_state;
    w_onehot_next = r_onehot;
    w_valid_next  = r_valid;
    w_last_next   = r_last;
    w_grant_clr   = 4'b0000;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_onehot_next = 4'b0001 << w_sel_idx;
          w_valid_next  = 1'b1;
          w_last_next   = w_sel_idx;
          w_grant_clr   = 4'b0001 << w_sel_idx;
          w_state_next  = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          w_onehot_next = 4'b0000;
          w_valid_next  = 1'b0;
          w_state_next  = IDLE;
        end
      end
      default: begin
        w_onehot_next = 4'b0000;
        w_valid_next  = 1'b0;
        w_state_next  = IDLE;
      end
    endcase
  end

  // Pending queue update: a new edge wins over a same-cycle grant clear; an
  // edge on an already-pending, not-granted bit is lost and flagged.
  always_comb begin
    w_pending_next  = (r_pending & ~w_grant_clr) | w_rise;
    w_overflow_next = |(w_rise & r_pending & ~w_grant_clr);
  end

  // State, grant and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_onehot   <= 4'b0000;
      r_valid    <= 1'b0;
      r_last     <= 2'd3;
      r_pending  <= 4'b0000;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_onehot   <= w_onehot_next;
      r_valid    <= w_valid_next;
      r_last     <= w_last_next;
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign onehot   = r_onehot;
  assign valid    = r_valid;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_req_onehot_capture.sv
// Testbench for req_onehot_capture: directed scenarios plus randomized
// stimulus, every cycle compared against a behavioural reference model.
module tb_req_onehot_capture;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       ack;
  logic [3:0] onehot;
  logic       valid;
  logic [3:0] pending;
  logic       overflow;

  int n_cmp;
  int n_err;

  // Reference model state
  bit [3:0]     m_s1, m_s2, m_db, m_evt, m_pend;
  bit           m_valid, m_ovf;
  int           m_grant, m_last;
  logic [255:0] m_hist [4];
  logic [255:0] mask;

  bit [3:0] grants[$];

  req_onehot_capture #(.DB_CYCLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack      (ack),
    .onehot   (onehot),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_evt = 0; m_pend = 0;
    m_valid = 0; m_ovf = 0; m_grant = 0; m_last = 3;
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
  endfunction

  // One rising clock edge of the specified behaviour, using the inputs
  // present just before the edge.
  function automatic void model_edge();
    int clr;
    bit ovf;
    if (rst) begin
      model_reset();
      return;
    end
    clr = -1;
    if (!m_valid) begin
      for (int k = 1; k <= 4; k++) begin
        int b;
        b = (m_last + k) % 4;
        if (clr < 0 && m_pend[b]) clr = b;
      end
    end
    ovf = 0;
    for (int b = 0; b < 4; b++) begin
      if (m_evt[b]) begin
        if (m_pend[b] && clr != b) ovf = 1;
        m_pend[b] = 1;
      end else if (clr == b) begin
        m_pend[b] = 0;
      end
    end
    if (clr >= 0) begin
      m_valid = 1; m_grant = clr; m_last = clr;
    end else if (m_valid && ack) begin
      m_valid = 0;
    end
    m_ovf = ovf;
    // Debounced level flips once the last N synchronized samples all differ.
    for (int b = 0; b < 4; b++) begin
      m_evt[b] = 0;
      m_hist[b] = {m_hist[b][254:0], m_s2[b]};
      if (!m_db[b] && ((m_hist[b] & mask) == mask)) begin
        m_db[b] = 1;
        m_evt[b] = 1;
      end else if (m_db[b] && ((m_hist[b] & mask) == '0)) begin
        m_db[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = req_in;
  endfunction

  task automatic compare_all();
    bit [3:0] eo;
    eo = m_valid ? (4'b0001 << m_grant) : 4'b0000;
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("onehot", {28'd0, onehot}, {28'd0, eo});
    chk("pending", {28'd0, pending}, {28'd0, m_pend});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic [3:0] r);
    req_in = r;
    ack = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_outputs", {19'd0, onehot, valid, pending, overflow}, 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && !valid; i++) step();
    chk("wait_valid", {31'd0, valid}, 32'd1);
  endtask

  task automatic run_acking(input int cycles);
    grants.delete();
    for (int i = 0; i < cycles; i++) begin
      ack = valid;
      if (valid) begin
        grants.push_back(onehot);
        $display("grant onehot=%b pending=%b t=%0t", onehot, pending, $time);
      end
      step();
    end
    ack = 1'b0;
  endtask

  initial begin
    logic [255:0] one;
    bit [3:0] exp_all[4];
    bit [3:0] exp_wrap[3];
    int cnt;
    n_cmp = 0;
    n_err = 0;
    one = 1;
    mask = (one << N) - one;
    req_in = 4'b0000;
    ack = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    do_reset(4'b0000);

    // Latency: bit 1 held high
    req_in = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 5) chk("lat_pend5", {28'd0, pending}, 32'h0);
      if (k == 6) chk("lat_pend6", {28'd0, pending}, 32'h2);
      if (k == 6) chk("lat_valid6", {31'd0, valid}, 32'd0);
      if (k == 7) chk("lat_onehot7", {27'd0, valid, onehot}, 32'h12);
      if (k == 7) chk("lat_pend7", {28'd0, pending}, 32'h0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_drop", {31'd0, valid}, 32'd0);
    $display("scenario latency done t=%0t", $time);

    // Short glitch is filtered
    do_reset(4'b0000);
    req_in = 4'b0001;
    step();
    step();
    req_in = 4'b0000;
    cnt = 0;
    repeat (12) begin
      step();
      if (pending != 0 || valid || overflow) cnt++;
    end
    chk("glitch_quiet", cnt, 0);
    $display("scenario glitch done t=%0t", $time);

    // All four together, granted in order
    do_reset(4'b0000);
    req_in = 4'b1111;
    run_acking(30);
    exp_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    chk("all_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("all_order", {28'd0, grants[i]}, {28'd0, exp_all[i]});

    // Round-robin wrap after bit 2
    do_reset(4'b0000);
    req_in = 4'b0100;
    wait_valid(20);
    chk("wrap_first", {28'd0, onehot}, 32'h4);
    req_in = 4'b1101;
    repeat (8) step();
    chk("wrap_pend", {28'd0, pending}, 32'h9);
    run_acking(20);
    exp_wrap = '{4'b0100, 4'b1000, 4'b0001};
    chk("wrap_count", grants.size(), 3);
    for (int i = 0; i < 3 && i < grants.size(); i++)
      chk("wrap_order", {28'd0, grants[i]}, {28'd0, exp_wrap[i]});

    // Overflow: second edge on a still-pending bit
    do_reset(4'b0000);
    req_in = 4'b0001;
    wait_valid(20);
    req_in = 4'b0011;
    repeat (8) step();
    chk("ovf_pend", {28'd0, pending}, 32'h2);
    req_in = 4'b0001;
    repeat (8) step();
    req_in = 4'b0011;
    cnt = 0;
    repeat (12) begin
      step();
      if (overflow) cnt++;
    end
    chk("ovf_pulses", cnt, 1);
    chk("ovf_pend_kept", {31'd0, pending[1]}, 32'd1);
    $display("scenario overflow done t=%0t", $time);

    // Reset during an active grant with queued events
    do_reset(4'b0000);
    req_in = 4'b0010;
    wait_valid(20);
    req_in = 4'b0111;
    repeat (8) step();
    chk("midrst_pend", {28'd0, pending}, 32'h5);
    chk("midrst_valid", {31'd0, valid}, 32'd1);
    do_reset(4'b0111);
    run_acking(20);
    chk("midrst_count", grants.size(), 3);
    if (grants.size() > 0) chk("midrst_first", {28'd0, grants[0]}, 32'h1);

    // Randomized traffic
    do_reset(4'b0000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(4'b0000);
      if ($urandom_range(0, 5) == 0) req_in = req_in ^ (4'b0001 << $urandom_range(0, 3));
      ack = ($urandom_range(0, 3) == 0);
      step();
    end
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
